// File: rtl/cpu_alu_pkg.sv
// Shared ALU definitions: default datapath width, flag bit positions within
// the 4-bit {N,Z,C,V} flag vector, and the add/subtract select encoding.
package cpu_alu_pkg;
    localparam int ALU_WIDTH = 16;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    typedef logic [3:0] flags_t;
endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the adder/subtractor, the result stage and the
// downstream consumer.
//   in_valid/in_ready   : upstream push handshake
//   sum, cout, sel      : adder result, carry out, op (0 add, 1 sub)
//   in0_msb, in1_msb    : raw operand sign bits for overflow
//   out_valid/out_ready : downstream pop handshake
//   out_res, out_flags  : head entry result and {N,Z,C,V}
//   last_flags          : flags of the most recently popped entry
// Modports: slave = result stage view, master = upstream/downstream view.
interface alu_result_stage_if #(
    parameter int WIDTH = cpu_alu_pkg::ALU_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             sel;
    logic             in0_msb;
    logic             in1_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic [3:0]       out_flags;
    logic [3:0]       last_flags;

    modport slave (
        input  in_valid, sum, cout, sel, in0_msb, in1_msb, out_ready,
        output in_ready, out_valid, out_res, out_flags, last_flags
    );

    modport master (
        output in_valid, sum, cout, sel, in0_msb, in1_msb, out_ready,
        input  in_ready, out_valid, out_res, out_flags, last_flags
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational {N,Z,C,V} generator for an adder/subtractor result.
// Ports: sum, cout, sel, in0_msb, in1_msb in; flags out.
// C is the raw carry out (no borrow inversion on subtract).
// Macro ALU_RESULT_OVF_EN: when defined V is computed from the operand and
// result sign bits; when undefined V is tied to 0 and the msb inputs and
// sel are unused.
module alu_flag_gen
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             sel,
    input  logic             in0_msb,
    input  logic             in1_msb,
    output flags_t           flags
);
    logic res_msb;
    assign res_msb = sum[WIDTH-1];

`ifdef ALU_RESULT_OVF_EN
    // Subtract flips the effective sign of in1, so the same-sign test inverts.
    logic ovf;
    always_comb begin
        if (sel == SEL_SUB)
            ovf = (in0_msb != in1_msb) && (res_msb != in0_msb);
        else
            ovf = (in0_msb == in1_msb) && (res_msb != in0_msb);
    end
`else
    logic ovf;
    logic unused_ovf_inputs;
    assign ovf               = 1'b0;
    assign unused_ovf_inputs = ^{sel, in0_msb, in1_msb};
`endif

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = res_msb;
        flags[FLAG_Z] = (sum == '0);
        flags[FLAG_C] = cout;
        flags[FLAG_V] = ovf;
    end
endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: captures adder/subtractor results with their flags into
// a small circular FIFO and presents the head entry downstream.
// Ports: clk, rst (sync, active-high), bus (alu_result_stage_if.slave).
// Flags are computed at push time by alu_flag_gen; an entry is visible on
// out_* the cycle after it is pushed, and outputs come only from registers.
// Optional overflow flag: macro ALU_RESULT_OVF_EN (see alu_flag_gen).
module alu_result_stage
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_result_stage_if.slave    bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_res   [DEPTH];
    flags_t           mem_flags [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    flags_t           last_flags;
    flags_t           new_flags;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .sum     (bus.sum),
        .cout    (bus.cout),
        .sel     (bus.sel),
        .in0_msb (bus.in0_msb),
        .in1_msb (bus.in1_msb),
        .flags   (new_flags)
    );

    // Both handshakes depend only on occupancy, never on the other side.
    assign in_ready  = (occ < CW'(DEPTH));
    assign out_valid = (occ != '0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    // DEPTH is a power of two, so pointers wrap naturally at PW bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            last_flags <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_res[i]   <= '0;
                mem_flags[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_res[wr_ptr]   <= bus.sum;
                mem_flags[wr_ptr] <= new_flags;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                last_flags <= mem_flags[rd_ptr];
                rd_ptr     <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_res    = mem_res[rd_ptr];
    assign bus.out_flags  = mem_flags[rd_ptr];
    assign bus.last_flags = last_flags;
endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width of result.
REQ-002 SHALL have parameter DEPTH, default 2, buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream adder/subtractor result valid this cycle.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 sum  input  WIDTH  adder/subtractor result.
REQ-008 cout  input  1  adder/subtractor carry out.
REQ-009 sel  input  1  operation: 0 = add, 1 = subtract.
REQ-010 in0_msb, in1_msb  input  1 each  sign bits of the raw operands in0, in1.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  downstream consumes head entry.
REQ-013 out_res  output  WIDTH  head entry result.
REQ-014 out_flags  output  4  head entry flags {N,Z,C,V}.
REQ-015 last_flags  output  4  flags of the most recently popped entry.

Function
REQ-016 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 Flags SHALL be computed at push: N = sum[WIDTH-1]; Z = (sum == 0); C = cout unmodified (no borrow inversion for subtract).
REQ-018 V SHALL be: add: in0_msb == in1_msb && sum msb != in0_msb; subtract: in0_msb != in1_msb && sum msb != in0_msb.
REQ-019 Entry SHALL appear on out_* one cycle after push (latency 1); no combinational in->out path.
REQ-020 Buffer SHALL be FIFO-ordered circular with read/write pointers wrapping modulo DEPTH and an occupancy counter 0..DEPTH.
REQ-021 in_ready SHALL be registered-state based: high iff occupancy < DEPTH; it SHALL NOT depend on out_ready.
REQ-022 out_valid SHALL be high iff occupancy > 0; out_res/out_flags SHALL hold steady while out_valid && !out_ready.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged, both pointers advancing.
REQ-024 Push when full SHALL be impossible (in_ready low); pop when empty SHALL be ignored.
REQ-025 last_flags SHALL update to the popped entry's flags on the pop edge, otherwise hold.

Reset
REQ-026 On rst high at clk edge: occupancy, pointers = 0; out_valid = 0; in_ready = 1 after reset; last_flags = 0; out_res/out_flags = 0.
REQ-027 Reset SHALL take priority over simultaneous push/pop; buffered entries mid-operation SHALL be discarded.

Configuration
REQ-028 Macro ALU_RESULT_OVF_EN: defined -> V computed per REQ-018; undefined -> V forced 0, in0_msb/in1_msb ignored, no overflow logic synthesized.

Structure
REQ-029 Shared package cpu_alu_pkg SHALL hold WIDTH default, flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0) and the sel encoding constants.
REQ-030 One combinational sub-module alu_flag_gen SHALL compute {N,Z,C,V} from sum, cout, sel, msbs; storage and handshake stay in alu_result_stage.

Verification
REQ-031 sum=0x1976, cout=0, sel=0, msbs 0/0, push, out_ready=1 -> next cycle out_res=0x1976, out_flags=0000.
REQ-032 sum=0xE976, cout=1, sel=0, msbs 1/1 -> out_flags=1010 (N,C set, V clear).
REQ-033 sum=0x8000, cout=0, sel=0, msbs 0/0 -> flags=1001 with ALU_RESULT_OVF_EN; 1000 without.
REQ-034 sum=0x0000, cout=1, sel=1, msbs 0/0 -> flags=0110; after pop last_flags=0110.
REQ-035 out_ready=0, three back-to-back pushes 0x0001,0x0002,0x0003 -> in_ready low after second, third held upstream; release out_ready -> outputs 0x0001,0x0002,0x0003 in order, no loss/duplication.
REQ-036 Two entries buffered, rst pulsed one cycle concurrent with in_valid -> next cycle out_valid=0, in_ready=1, last_flags=0, pushed entry not captured.
